// File: rtl/typed_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_REQ typed valid/ready sources share one
// registered output stage, and a grant is held from first beat through the last beat.
module typed_rr_arbiter #(
    parameter type TYPE_T = logic [255:0],
    parameter int NUM_REQ = 4,
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  TYPE_T              in_data [NUM_REQ],
    input  logic [NUM_REQ-1:0] in_valid,
    input  logic [NUM_REQ-1:0] in_last,
    output logic [NUM_REQ-1:0] in_ready,
    output TYPE_T              out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SRC_W-1:0]   out_src,
    input  logic               out_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] ptr_after;
    logic             any_valid;
    logic             found;
    logic             out_free;
    logic             accept;
    int               cand;

    // Rotating priority search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        cand   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && in_valid[cand]) begin
                winner = SRC_W'(cand);
                found  = 1'b1;
            end
        end
    end

    assign any_valid = |in_valid;
    assign out_free  = !out_valid || out_ready;
    assign accept    = (state == LOCKED) && in_valid[grant] && out_free;
    assign ptr_after = (int'(grant) == NUM_REQ - 1) ? '0 : grant + SRC_W'(1);

    always_comb begin
        in_ready = '0;
        if (state == LOCKED) in_ready[grant] = out_free;
    end

    // Arbitration FSM and output register; a refill in the same cycle as an
    // output handshake keeps a packet streaming at full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= winner;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && in_last[grant]) begin
                        state  <= IDLE;
                        rr_ptr <= ptr_after;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                out_data  <= in_data[grant];
                out_last  <= in_last[grant];
                out_src   <= grant;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_typed_rr_arbiter.sv
// Self-checking bench for typed_rr_arbiter: table vectors, directed corner sequences
// and randomized traffic compared against a transaction-level reference model.
module tb_typed_rr_arbiter;

    localparam int N = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef logic [255:0] data_t;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         rdy;
        logic         rst;
        logic [N-1:0] ir;
        logic         ov;
        int           src;
        logic         last;
        int           tag;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    data_t        in_data [N];
    logic [N-1:0] in_valid;
    logic [N-1:0] in_last;
    logic [N-1:0] in_ready;
    data_t        out_data;
    logic         out_valid;
    logic         out_last;
    logic [1:0]   out_src;
    logic         out_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: owner = -1 when no packet is being carried.
    int    m_owner;
    int    m_ptr;
    logic  m_valid;
    logic  m_last;
    data_t m_data;
    int    m_src;

    vec_t vecs[$];

    always #5 clk = ~clk;

    typed_rr_arbiter #(.TYPE_T(data_t), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_src(out_src), .out_ready(out_ready)
    );

    task automatic check(input string name, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] modelReady();
        logic [N-1:0] r = '0;
        if (m_owner >= 0 && (!m_valid || out_ready)) r[m_owner] = 1'b1;
        return r;
    endfunction

    task automatic modelReset();
        m_owner = -1;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        m_src   = 0;
    endtask

    task automatic modelStep();
        logic [N-1:0] rdy;
        logic         acc;
        logic         got;
        int           w;
        rdy = modelReady();
        acc = (m_owner >= 0) && in_valid[m_owner] && rdy[m_owner];
        if (acc) begin
            m_data  = in_data[m_owner];
            m_last  = in_last[m_owner];
            m_src   = m_owner;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            got = 1'b0;
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (!got && in_valid[w]) begin
                    m_owner = w;
                    got = 1'b1;
                end
            end
        end else if (acc && in_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic rdy, input logic rst, input int tag);
        in_valid  = v;
        in_last   = l;
        out_ready = rdy;
        rst_n     = !rst;
        for (int i = 0; i < N; i++) in_data[i] = data_t'(tag * 16 + i);
        #1;
        if (rst) modelReset();
    endtask

    task automatic checkOutput();
        check("in_ready", data_t'(in_ready), data_t'(modelReady()));
        check("out_valid", data_t'(out_valid), data_t'(m_valid));
        check("out_data", out_data, m_data);
        check("out_last", data_t'(out_last), data_t'(m_last));
        check("out_src", data_t'(out_src), data_t'(m_src));
    endtask

    task automatic advanceCycle(input logic rst);
        if (!rst) modelStep();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycleStep(input logic [N-1:0] v, input logic [N-1:0] l,
                             input logic rdy, input logic rst);
        applyStimulus(v, l, rdy, rst, cyc);
        checkOutput();
        advanceCycle(rst);
    endtask

    task automatic addVec(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy,
                          input logic rst, input logic [N-1:0] ir, input logic ov,
                          input int src, input logic last, input int tag);
        vec_t e;
        e.v = v; e.l = l; e.rdy = rdy; e.rst = rst; e.ir = ir;
        e.ov = ov; e.src = src; e.last = last; e.tag = tag;
        vecs.push_back(e);
    endtask

    initial begin
        int           beats;
        int           out1;
        logic         seen2;
        logic         stall;
        data_t        prev_data;
        logic [1:0]   prev_src;
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         rdy;
        logic         rst;
        int           left [N];
        logic [11:0]  bp_pattern;

        rst_n = 1'b0;
        in_valid = '0;
        in_last = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        modelReset();
        @(posedge clk);
        #1;
        check("reset_in_ready", data_t'(in_ready), '0);
        check("reset_out_valid", data_t'(out_valid), '0);
        check("reset_out_data", out_data, '0);
        check("reset_out_src", data_t'(out_src), '0);
        check("reset_out_last", data_t'(out_last), '0);
        @(posedge clk);
        #1;

        // Requester 0 three-beat packet, then all four streaming single-beat packets.
        addVec(4'b0001, 4'b0000, H, L, 4'b0000, L, 0, L, 0);
        addVec(4'b0001, 4'b0000, H, L, 4'b0001, L, 0, L, 0);
        addVec(4'b0001, 4'b0000, H, L, 4'b0001, H, 0, L, 1);
        addVec(4'b0001, 4'b0001, H, L, 4'b0001, H, 0, L, 2);
        addVec(4'b0000, 4'b0000, H, L, 4'b0000, H, 0, H, 3);
        addVec(4'b0000, 4'b0000, H, L, 4'b0000, L, 0, L, 0);
        addVec(4'b0000, 4'b0000, H, H, 4'b0000, L, 0, L, 0);
        addVec(4'b1111, 4'b1111, H, L, 4'b0000, L, 0, L, 0);
        addVec(4'b1111, 4'b1111, H, L, 4'b0001, L, 0, L, 0);
        addVec(4'b1111, 4'b1111, H, L, 4'b0000, H, 0, H, 8);
        addVec(4'b1111, 4'b1111, H, L, 4'b0010, L, 0, L, 0);
        addVec(4'b1111, 4'b1111, H, L, 4'b0000, H, 1, H, 10);
        addVec(4'b1111, 4'b1111, H, L, 4'b0100, L, 0, L, 0);
        addVec(4'b1111, 4'b1111, H, L, 4'b0000, H, 2, H, 12);
        addVec(4'b1111, 4'b1111, H, L, 4'b1000, L, 0, L, 0);
        addVec(4'b1111, 4'b1111, H, L, 4'b0000, H, 3, H, 14);
        addVec(4'b1111, 4'b1111, H, L, 4'b0001, L, 0, L, 0);
        addVec(4'b1111, 4'b1111, H, L, 4'b0000, H, 0, H, 16);
        addVec(4'b1111, 4'b1111, H, L, 4'b0010, L, 0, L, 0);
        addVec(4'b0000, 4'b0000, H, L, 4'b0000, H, 1, H, 18);
        addVec(4'b0000, 4'b0000, H, L, 4'b0000, L, 0, L, 0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].v, vecs[k].l, vecs[k].rdy, vecs[k].rst, k);
            checkOutput();
            check("tbl_in_ready", data_t'(in_ready), data_t'(vecs[k].ir));
            check("tbl_out_valid", data_t'(out_valid), data_t'(vecs[k].ov));
            if (vecs[k].ov) begin
                check("tbl_out_data", out_data, data_t'(vecs[k].tag * 16 + vecs[k].src));
                check("tbl_out_src", data_t'(out_src), data_t'(vecs[k].src));
                check("tbl_out_last", data_t'(out_last), data_t'(vecs[k].last));
            end
            advanceCycle(vecs[k].rst);
        end

        // Requester 1 holds a 4-beat packet while requester 2 keeps asking.
        cycleStep('0, '0, H, H);
        beats = 0;
        out1 = 0;
        seen2 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            v = {1'b0, 1'b1, (beats < 4), 1'b0};
            l = {1'b0, 1'b1, (beats == 3), 1'b0};
            applyStimulus(v, l, H, L, cyc);
            checkOutput();
            if (out_valid && out_src == 2'd2) begin
                check("req2_after_req1_last", data_t'(out1), data_t'(4));
                seen2 = 1'b1;
            end
            if (out_valid && out_ready && out_src == 2'd1) out1++;
            if (in_valid[1] && in_ready[1]) beats++;
            advanceCycle(L);
        end
        check("req2_granted_next", data_t'(seen2), data_t'(1));

        // Backpressure mid-packet: held output, no ready upstream while stalled.
        cycleStep('0, '0, H, H);
        beats = 0;
        stall = 1'b0;
        prev_data = '0;
        prev_src = '0;
        bp_pattern = 12'b1111_1100_0111;
        for (int c = 0; c < 12; c++) begin
            v = {3'b000, (beats < 4)};
            l = {3'b000, (beats == 3)};
            applyStimulus(v, l, bp_pattern[c], L, cyc);
            checkOutput();
            if (stall) begin
                check("bp_hold_data", out_data, prev_data);
                check("bp_hold_src", data_t'(out_src), data_t'(prev_src));
            end
            if (out_valid && !out_ready) check("bp_no_ready", data_t'(in_ready), '0);
            stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_src = out_src;
            if (in_valid[0] && in_ready[0]) beats++;
            advanceCycle(L);
        end

        // Granted requester 3 goes quiet mid-packet while requester 0 waits.
        cycleStep('0, '0, H, H);
        cycleStep(4'b1000, 4'b0000, H, L);
        cycleStep(4'b1000, 4'b0000, H, L);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0001, 4'b0000, H, L, cyc);
            checkOutput();
            check("waiting_req0_blocked", data_t'(in_ready[0]), '0);
            check("grant_held_on_3", data_t'(in_ready[3]), data_t'(1));
            advanceCycle(L);
        end
        cycleStep(4'b1001, 4'b1000, H, L);
        for (int c = 0; c < 3; c++) cycleStep(4'b0001, 4'b0001, H, L);

        // Reset mid-packet, then the pointer restarts at requester 0.
        cycleStep('0, '0, H, H);
        cycleStep(4'b0100, 4'b0000, H, L);
        cycleStep(4'b0100, 4'b0000, H, L);
        cycleStep(4'b0100, 4'b0000, H, L);
        applyStimulus(4'b0100, 4'b0000, H, H, cyc);
        checkOutput();
        check("rst_out_valid", data_t'(out_valid), '0);
        check("rst_in_ready", data_t'(in_ready), '0);
        advanceCycle(H);
        cycleStep(4'b0101, 4'b0101, H, L);
        applyStimulus(4'b0101, 4'b0101, H, L, cyc);
        checkOutput();
        check("rst_first_grant_0", data_t'(in_ready), data_t'(4'b0001));
        advanceCycle(L);

        // Randomized traffic with random packet lengths, gaps and backpressure.
        for (int i = 0; i < N; i++) left[i] = $urandom_range(1, 4);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 9) < 7);
                l[i] = (left[i] == 1);
            end
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus(v, l, rdy, rst, cyc);
            checkOutput();
            if (rst) begin
                for (int i = 0; i < N; i++) left[i] = $urandom_range(1, 4);
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && in_ready[i]) begin
                        left[i]--;
                        if (left[i] == 0) left[i] = $urandom_range(1, 4);
                    end
                end
            end
            advanceCycle(rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
